// File: rtl/cnn_mem_pkg.sv
// rtl/cnn_mem_pkg.sv - shared types and constants for the CONV memory responder
package cnn_mem_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_ARM,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    localparam int DEF_DW        = 20;
    localparam int DEF_AW        = 12;
    localparam int DEF_IMG_DEPTH = 4096;
    localparam int DEF_L0_DEPTH  = 4096;
    localparam int DEF_L1_DEPTH  = 1024;

endpackage

// File: rtl/cnn_mem_bank.sv
// rtl/cnn_mem_bank.sv - single-port-write, asynchronous-read storage bank
module cnn_mem_bank #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 20,
    parameter int ABITS = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ABITS-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents survive reset; a same-cycle read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cnn_mem_responder.sv
// rtl/cnn_mem_responder.sv - image/layer memory responder for CONV; optional CNN_MEM_PROTECT_EN
module cnn_mem_responder
    import cnn_mem_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int IMG_DEPTH = DEF_IMG_DEPTH,
    parameter int L0_DEPTH  = DEF_L0_DEPTH,
    parameter int L1_DEPTH  = DEF_L1_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic [2:0]    csel,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic          dump_sel,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          done,
    input  logic          restart
`ifdef CNN_MEM_PROTECT_EN
    ,
    output logic          err_flag
`endif
);

    localparam int IAW = $clog2(IMG_DEPTH);
    localparam int L0W = $clog2(L0_DEPTH);
    localparam int L1W = $clog2(L1_DEPTH);
    localparam int DCW = $clog2(L0_DEPTH + L1_DEPTH);

    state_t state, state_nx;
    logic [IAW-1:0] ld_cnt;
    logic [DCW-1:0] dump_cnt;
    logic           ld_fire, dump_fire, dump_last, ld_last;

    logic [DW-1:0]  img_rdata, l0_rdata, l1_rdata, rd_data, cdata_hold;
    logic [L0W-1:0] l0_raddr;
    logic [L1W-1:0] l1_raddr;
    logic           run, sel_l0, sel_l1, l0_we, l1_we;
    logic           rd_ok, rd_bad, wr_bad;
    logic           dump_in_l1;
    logic [AW-1:0]  dump_off;

    assign ld_last   = (ld_cnt == IAW'(IMG_DEPTH - 1));
    assign dump_last = (dump_cnt == DCW'(L0_DEPTH + L1_DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ld_ready   = 1'b0;
        ready      = 1'b0;
        dump_valid = 1'b0;
        done       = 1'b0;
        case (state)
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && ld_last) state_nx = ST_ARM;
            end
            ST_ARM: begin
                ready = 1'b1;
                if (busy) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (!busy) state_nx = ST_DUMP;
            end
            ST_DUMP: begin
                dump_valid = 1'b1;
                if (dump_ready && dump_last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (restart) state_nx = ST_LOAD;
            end
            default: state_nx = ST_LOAD;
        endcase
    end

    assign ld_fire   = ld_valid && ld_ready;
    assign dump_fire = dump_valid && dump_ready;

    // Both counters wrap to zero on their final beat, so LOAD always restarts at word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt   <= '0;
            dump_cnt <= '0;
        end else begin
            if (ld_fire) ld_cnt <= ld_last ? '0 : ld_cnt + 1'b1;
            if (dump_fire) dump_cnt <= dump_last ? '0 : dump_cnt + 1'b1;
        end
    end

    assign dump_in_l1 = (dump_cnt >= DCW'(L0_DEPTH));
    assign dump_off   = AW'(dump_in_l1 ? dump_cnt - DCW'(L0_DEPTH) : dump_cnt);
    assign dump_sel   = dump_in_l1;
    assign dump_addr  = dump_off;
    assign dump_data  = dump_in_l1 ? l1_rdata : l0_rdata;

    assign run    = (state == ST_RUN);
    assign sel_l0 = (csel == CSEL_L0);
    assign sel_l1 = (csel == CSEL_L1);

`ifdef CNN_MEM_PROTECT_EN
    logic csel_bad;
    assign csel_bad = !(sel_l0 || sel_l1);
    assign wr_bad   = cwr && (!run || csel_bad || (sel_l1 && caddr_wr[AW-1:L1W] != '0));
    assign rd_bad   = crd && (!run || csel_bad || (sel_l1 && caddr_rd[AW-1:L1W] != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if (state == ST_DONE && restart) begin
            err_flag <= 1'b0;
        end else if (wr_bad || rd_bad) begin
            err_flag <= 1'b1;
        end
    end
`else
    assign wr_bad = 1'b0;
    assign rd_bad = 1'b0;
`endif

    assign l0_we = cwr && run && sel_l0 && !wr_bad;
    assign l1_we = cwr && run && sel_l1 && !wr_bad;

    // The dump walker owns the layer read ports once CONV has finished.
    assign l0_raddr = (state == ST_DUMP) ? dump_off[L0W-1:0] : caddr_rd[L0W-1:0];
    assign l1_raddr = (state == ST_DUMP) ? dump_off[L1W-1:0] : caddr_rd[L1W-1:0];

    assign rd_ok   = crd && run && (sel_l0 || sel_l1) && !rd_bad;
    assign rd_data = sel_l0 ? l0_rdata : l1_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdata_hold <= '0;
        end else if (rd_ok) begin
            cdata_hold <= rd_data;
        end else if (rd_bad) begin
            cdata_hold <= '0;
        end
    end

    assign cdata_rd = rd_ok ? rd_data : (rd_bad ? '0 : cdata_hold);
    assign idata    = run ? img_rdata : '0;

    cnn_mem_bank #(.DEPTH(IMG_DEPTH), .WIDTH(DW)) u_img (
        .clk   (clk),
        .we    (ld_fire),
        .waddr (ld_cnt),
        .wdata (ld_data),
        .raddr (iaddr[IAW-1:0]),
        .rdata (img_rdata)
    );

    cnn_mem_bank #(.DEPTH(L0_DEPTH), .WIDTH(DW)) u_l0 (
        .clk   (clk),
        .we    (l0_we),
        .waddr (caddr_wr[L0W-1:0]),
        .wdata (cdata_wr),
        .raddr (l0_raddr),
        .rdata (l0_rdata)
    );

    cnn_mem_bank #(.DEPTH(L1_DEPTH), .WIDTH(DW)) u_l1 (
        .clk   (clk),
        .we    (l1_we),
        .waddr (caddr_wr[L1W-1:0]),
        .wdata (cdata_wr),
        .raddr (l1_raddr),
        .rdata (l1_rdata)
    );

endmodule

// File: tb/tb_cnn_mem_responder.sv
// tb/tb_cnn_mem_responder.sv - randomized scoreboard bench for cnn_mem_responder
module tb_cnn_mem_responder;

    localparam int DW = 20;
    localparam int AW = 12;

    logic          clk;
    logic          reset;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;
    logic          dump_valid;
    logic          dump_ready;
    logic          dump_sel;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          done;
    logic          restart;
`ifdef CNN_MEM_PROTECT_EN
    logic          err_flag;
`endif

    cnn_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ready      (ready),
        .busy       (busy),
        .iaddr      (iaddr),
        .idata      (idata),
        .crd        (crd),
        .caddr_rd   (caddr_rd),
        .cdata_rd   (cdata_rd),
        .cwr        (cwr),
        .caddr_wr   (caddr_wr),
        .cdata_wr   (cdata_wr),
        .csel       (csel),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_sel   (dump_sel),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .done       (done),
        .restart    (restart)
`ifdef CNN_MEM_PROTECT_EN
        ,
        .err_flag   (err_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays holding what each memory should contain.
    logic [DW-1:0] m_img [4096];
    logic [DW-1:0] m_l0  [4096];
    logic [DW-1:0] m_l1  [1024];
    logic [63:0]   exp_q [$];
    logic [DW-1:0] last_rd;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            beats    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(input logic [2:0] s, input logic [11:0] a, input logic [DW-1:0] d);
        if (s == 3'b001) begin
            m_l0[a] = d;
        end else if (s == 3'b011) begin
`ifdef CNN_MEM_PROTECT_EN
            if (a[11:10] == 2'b00) m_l1[a[9:0]] = d;
`else
            m_l1[a[9:0]] = d;
`endif
        end
    endfunction

    task automatic do_write(input logic [2:0] s, input logic [11:0] a, input logic [DW-1:0] d);
        cwr = 1'b1; csel = s; caddr_wr = a; cdata_wr = d;
        model_write(s, a, d);
        step();
        cwr = 1'b0;
    endtask

    task automatic load_image(input bit rnd);
        int acc = 0;
        int cyc = 0;
        bit bad = 1'b0;
        while (acc < 4096 && cyc < 20000) begin
            ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data  = rnd ? DW'($urandom) : DW'(acc);
            @(negedge clk);
            if (ready || !ld_ready) bad = 1'b1;
            if (ld_valid) begin
                m_img[acc] = ld_data;
                acc++;
            end
            step();
            cyc++;
        end
        ld_valid = 1'b0;
        check("load_no_early_ready", bad, 0);
        check("load_count", acc, 4096);
        check("arm_after_load", {ld_ready, ready}, 2'b01);
    endtask

    task automatic run_dump(input int stop_at);
        int cyc = 0;
        exp_q.delete();
        for (int a = 0; a < 4096; a++) exp_q.push_back(64'({1'b0, 12'(a), m_l0[a]}));
        for (int a = 0; a < 1024; a++) exp_q.push_back(64'({1'b1, 12'(a), m_l1[a]}));
        beats = 0;
        busy = 1'b0; crd = 1'b0; cwr = 1'b0;
        step();
        check("dump_enter", dump_valid, 1);
        while (!done && cyc < 30000 && !(stop_at > 0 && beats >= stop_at)) begin
            dump_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        dump_ready = 1'b0;
        check("dump_within_budget", cyc < 30000, 1);
    endtask

    // Monitor: every cycle the DUT offers a beat it must match the scoreboard head,
    // which also proves the outputs are stable across stalls.
    always @(negedge clk) begin
        if (!reset && dump_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dump_extra_beat: got sel=%0d addr=0x%0h with no beat expected", dump_sel, dump_addr);
            end else begin
                check("dump_beat", 64'({dump_sel, dump_addr, dump_data}), exp_q[0]);
                if (dump_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]    s;
        logic [11:0]   ra, wa;
        logic [DW-1:0] wd, ev;
        int            op;

        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; busy = 1'b0; iaddr = '0;
        crd = 1'b0; caddr_rd = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
        csel = 3'b000; dump_ready = 1'b0; restart = 1'b0; last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {ready, dump_valid, done}, 3'b000);
        check("reset_idata", idata, 0);
        check("reset_cdata_rd", cdata_rd, 0);
        reset = 1'b0;
        step();
        check("load_ld_ready", ld_ready, 1);

        load_image(1'b0);

        repeat (3) step();
        check("arm_waits_for_busy", ready, 1);
        busy = 1'b1;
        @(negedge clk);
        check("ready_before_busy_edge", ready, 1);
        step();
        check("ready_dropped_in_run", ready, 0);
        iaddr = 12'h123;
        @(negedge clk);
        check("idata_0x123", idata, 20'h00123);

        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_ignored_in_run", {ld_ready, ready, dump_valid, done}, 4'b0000);

        repeat (8) begin
            ra = 12'($urandom);
            iaddr = ra;
            @(negedge clk);
            check("idata_random", idata, m_img[ra]);
            step();
        end

        for (int a = 0; a < 4096; a++) do_write(3'b001, 12'(a), DW'($urandom));
        for (int a = 0; a < 1024; a++) do_write(3'b011, 12'(a), DW'($urandom));

        do_write(3'b001, 12'd5, 20'hABCDE);
        crd = 1'b1; csel = 3'b001; caddr_rd = 12'd5;
        @(negedge clk);
        check("l0_read_back", cdata_rd, 20'hABCDE);
        step();
        crd = 1'b0; caddr_rd = 12'd9;
        @(negedge clk);
        check("l0_read_hold", cdata_rd, 20'hABCDE);
        step();

        do_write(3'b011, 12'd7, 20'h11111);
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd7; cdata_wr = 20'h22222;
        crd = 1'b1; caddr_rd = 12'd7;
        @(negedge clk);
        check("l1_rw_same_cycle_old", cdata_rd, 20'h11111);
        model_write(3'b011, 12'd7, 20'h22222);
        step();
        cwr = 1'b0;
        @(negedge clk);
        check("l1_rw_next_cycle_new", cdata_rd, 20'h22222);
        step();
        crd = 1'b0;
        last_rd = 20'h22222;

`ifdef CNN_MEM_PROTECT_EN
        check("err_flag_clear", err_flag, 0);
        cwr = 1'b1; csel = 3'b010; caddr_wr = 12'd9; cdata_wr = 20'h5A5A5;
        @(negedge clk);
        check("err_flag_not_yet", err_flag, 0);
        step();
        cwr = 1'b0;
        check("err_flag_set", err_flag, 1);
`endif

        repeat (300) begin
            op = $urandom_range(0, 4);
            case (op)
                0: do_write(3'b001, 12'($urandom), DW'($urandom));
                1: do_write(3'b011, 12'($urandom), DW'($urandom));
                2: begin
                    s  = $urandom_range(0, 1) ? 3'b011 : 3'b001;
                    ra = (s == 3'b011) ? {2'b00, 10'($urandom)} : 12'($urandom);
                    ev = (s == 3'b011) ? m_l1[ra[9:0]] : m_l0[ra];
                    wa = ($urandom_range(0, 3) == 0) ? ra : 12'($urandom);
                    wd = DW'($urandom);
                    crd = 1'b1; csel = s; caddr_rd = ra;
                    cwr = 1'($urandom_range(0, 1)); caddr_wr = wa; cdata_wr = wd;
                    @(negedge clk);
                    check("rand_read", cdata_rd, ev);
                    last_rd = ev;
                    if (cwr) model_write(s, wa, wd);
                    step();
                    crd = 1'b0; cwr = 1'b0;
                end
                3: begin
                    crd = 1'b0; csel = 3'($urandom); caddr_rd = 12'($urandom);
                    @(negedge clk);
                    check("rand_hold", cdata_rd, last_rd);
                    step();
                end
                default: begin
                    s = 3'($urandom);
                    if (s == 3'b001 || s == 3'b011) s = 3'b110;
                    do_write(s, 12'($urandom), DW'($urandom));
                end
            endcase
        end

        run_dump(0);
        check("done_after_dump", {done, dump_valid}, 2'b10);
        check("scoreboard_drained", exp_q.size(), 0);

        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_to_load", {ld_ready, done}, 2'b10);
`ifdef CNN_MEM_PROTECT_EN
        check("err_flag_cleared_by_restart", err_flag, 0);
`endif

        load_image(1'b1);
        busy = 1'b1;
        step();
        check("second_run_ready_low", ready, 0);
        repeat (6) begin
            ra = 12'($urandom);
            iaddr = ra;
            @(negedge clk);
            check("idata_second_image", idata, m_img[ra]);
            step();
        end
        repeat (10) do_write($urandom_range(0, 1) ? 3'b011 : 3'b001, 12'($urandom), DW'($urandom));

        run_dump(100);
        check("reached_beat_100", beats, 100);
        reset = 1'b1;
        #1;
        check("reset_drops_dump_valid", {dump_valid, ready}, 2'b00);
        exp_q.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("after_reset_load", {ld_ready, done, dump_valid}, 3'b100);
        step();

        load_image(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
